// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//   Packs instruction field bundles into 32-bit instruction words and streams
//   them into instruction memory through a backpressured write port. It is
//   the inverse of the decode stage: the immediate scattering matches what
//   the team's decoder reads back. The program loader and self-checking
//   benches use it to build instruction streams for the core.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           pulse: load start_addr, clear word_cnt, enter RUN
//   start_addr      first word address of the stream
//   in_valid        field bundle valid
//   in_ready        encoder takes a bundle this cycle
//   cls             class: 0 R, 1 I-arith, 2 load, 3 store, 4 branch,
//                   5 jal, 6 jalr, 7 lui
//   funct3, funct7  function fields
//   rd, rs1, rs2    register fields
//   imm             immediate; only the low bits the class uses matter
//   mem_we          write request valid, held until mem_ready
//   mem_addr        write word address
//   mem_wdata       encoded instruction word
//   mem_ready       memory accepts the write when mem_we & mem_ready
//   busy            state is RUN
//   full            state is FULL (last address written)
//   err             one-cycle pulse: illegal bundle was dropped
//   word_cnt        words written since start
// ---------------------------------------------------------------------------
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [19:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_I    = 3'd1;
    localparam logic [2:0] CLS_LD   = 3'd2;
    localparam logic [2:0] CLS_ST   = 3'd3;
    localparam logic [2:0] CLS_BR   = 3'd4;
    localparam logic [2:0] CLS_JAL  = 3'd5;
    localparam logic [2:0] CLS_JALR = 3'd6;
    localparam logic [2:0] CLS_LUI  = 3'd7;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        last_addr;
    logic        accept;
    logic        wr_done;

    // ------------------------------------------------------------------
    // Field packing and legality check
    // ------------------------------------------------------------------
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (cls)
            CLS_R: begin
                enc_word  = {funct7, rs2, rs1, funct3, rd, OPC_R};
                enc_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            CLS_I: begin
                // Shifts carry funct7 in the top bits and a 5-bit shamt.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    enc_word = {funct7, imm[4:0], rs1, funct3, rd, OPC_I};
                else
                    enc_word = {imm[11:0], rs1, funct3, rd, OPC_I};
            end
            CLS_LD: begin
                enc_word  = {imm[11:0], rs1, funct3, rd, OPC_LD};
                enc_legal = !(funct3 == 3'b011 || funct3 == 3'b110 ||
                              funct3 == 3'b111);
            end
            CLS_ST: begin
                enc_word  = {imm[6:0], rs2, rs1, funct3, imm[11:7], OPC_ST};
                enc_legal = (funct3 <= 3'b010);
            end
            CLS_BR: begin
                enc_word  = {imm[0], imm[7:2], rs2, rs1, funct3,
                             imm[11:8], imm[1], OPC_BR};
                enc_legal = !(funct3 == 3'b010 || funct3 == 3'b011);
            end
            CLS_JAL: begin
                enc_word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, OPC_JAL};
            end
            CLS_JALR: begin
                // jalr has a single form; funct3 is not taken from the bundle.
                enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            end
            CLS_LUI: begin
                enc_word = {imm, rd, OPC_LUI};
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign last_addr = (mem_addr == {ADDR_W{1'b1}});
    assign wr_done   = mem_we && mem_ready;

    // A completing write to the top address ends the stream on this edge, so
    // no new bundle may be taken alongside it. start always wins the cycle.
    assign in_ready = (state == S_RUN) && !start &&
                      (!mem_we || (mem_ready && !last_addr));
    assign accept   = in_valid && in_ready;

    assign busy = (state == S_RUN);
    assign full = (state == S_FULL);

    // ------------------------------------------------------------------
    // Control and write port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            word_cnt  <= '0;
            err       <= 1'b0;
        end else if (start) begin
            // Any pending write is dropped; the stream restarts cleanly.
            state    <= S_RUN;
            mem_we   <= 1'b0;
            mem_addr <= start_addr;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (wr_done) begin
                mem_we   <= 1'b0;
                mem_addr <= mem_addr + ADDR_ONE;
                word_cnt <= word_cnt + CNT_ONE;
                if (last_addr)
                    state <= S_FULL;
            end
            // A bundle taken on the completing edge overrides the clear above,
            // giving one word per cycle while mem_ready stays high.
            if (accept) begin
                if (enc_legal) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= enc_word;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  sa8;
    logic [1:0]  sa2;
    logic        in_valid;
    logic [2:0]  cls;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [19:0] imm;
    logic        mem_ready;

    logic        in_ready, mem_we, busy, full, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_cnt;

    logic        s_in_ready, s_mem_we, s_busy, s_full, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_word_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(sa8),
        .in_valid(in_valid), .in_ready(in_ready), .cls(cls),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .full(full), .err(err), .word_cnt(word_cnt)
    );

    inst_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .start_addr(sa2),
        .in_valid(in_valid), .in_ready(s_in_ready), .cls(cls),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_ready(mem_ready), .busy(s_busy),
        .full(s_full), .err(s_err), .word_cnt(s_word_cnt)
    );

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [19:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input logic [2:0] c, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] d,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic [19:0] im, input bit lg,
                                input logic [31:0] w);
        vec_t v;
        v.cls = c; v.f3 = f3; v.f7 = f7; v.rd = d; v.rs1 = s1; v.rs2 = s2;
        v.imm = im; v.legal = lg; v.word = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_add();
        cls = 3'd0; funct3 = 3'd0; funct7 = 7'd0;
        rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = 20'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_addr;

        //       cls   f3    f7     rd  rs1 rs2 imm         legal word
        vt[0]  = mk(3'd0, 3'd0, 7'h00, 1,  2,  3,  20'h00000, 1, 32'h003100B3); // add
        vt[1]  = mk(3'd0, 3'd0, 7'h20, 5,  6,  7,  20'h00000, 1, 32'h407302B3); // sub
        vt[2]  = mk(3'd0, 3'd0, 7'h01, 5,  6,  7,  20'h00000, 0, 32'h0);        // bad f7
        vt[3]  = mk(3'd1, 3'd0, 7'h00, 1,  0,  0,  20'h00FFF, 1, 32'hFFF00093); // addi -1
        vt[4]  = mk(3'd1, 3'd5, 7'h20, 2,  3,  0,  20'h00FE5, 1, 32'h4051D113); // srai 5
        vt[5]  = mk(3'd2, 3'd2, 7'h00, 4,  2,  0,  20'h00008, 1, 32'h00812203); // lw
        vt[6]  = mk(3'd2, 3'd3, 7'h00, 4,  2,  0,  20'h00008, 0, 32'h0);        // bad load
        vt[7]  = mk(3'd3, 3'd2, 7'h00, 0,  2,  5,  20'h007FF, 1, 32'hFE5127A3); // sw
        vt[8]  = mk(3'd3, 3'd3, 7'h00, 0,  2,  5,  20'h007FF, 0, 32'h0);        // bad store
        vt[9]  = mk(3'd4, 3'd0, 7'h00, 0,  1,  2,  20'h00001, 1, 32'h80208063); // beq
        vt[10] = mk(3'd4, 3'd1, 7'h00, 0,  3,  4,  20'h00ABE, 1, 32'h5E419AE3); // bne
        vt[11] = mk(3'd4, 3'd2, 7'h00, 0,  3,  4,  20'h00ABE, 0, 32'h0);        // bad br
        vt[12] = mk(3'd5, 3'd0, 7'h00, 1,  0,  0,  20'hABCDE, 1, 32'h9BD570EF); // jal
        vt[13] = mk(3'd6, 3'd3, 7'h00, 1,  5,  0,  20'h00010, 1, 32'h010280E7); // jalr
        vt[14] = mk(3'd7, 3'd0, 7'h00, 3,  0,  0,  20'h12345, 1, 32'h123451B7); // lui
        vt[15] = mk(3'd2, 3'd4, 7'h00, 7,  8,  0,  20'hFFFFF, 1, 32'hFFF44383); // lbu

        rst = 1'b1; start = 1'b0; sa8 = 8'd0; sa2 = 2'd0; in_valid = 1'b0;
        mem_ready = 1'b1;
        set_add();
        tick(); tick();

        // Reset state
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);

        // Table-driven encodings streamed back to back from address 0
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy", busy, 1);
        exp_addr = 0;
        for (int i = 0; i < 16; i++) begin
            cls = vt[i].cls; funct3 = vt[i].f3; funct7 = vt[i].f7;
            rd = vt[i].rd; rs1 = vt[i].rs1; rs2 = vt[i].rs2; imm = vt[i].imm;
            in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_addr", i), mem_addr, exp_addr);
            check($sformatf("vec%0d_word_cnt", i), word_cnt, exp_addr);
            if (vt[i].legal) begin
                check($sformatf("vec%0d_we", i), mem_we, 1);
                check($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].word);
                check($sformatf("vec%0d_err", i), err, 0);
                exp_addr++;
            end else begin
                check($sformatf("vec%0d_we", i), mem_we, 0);
                check($sformatf("vec%0d_err", i), err, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_we", mem_we, 0);
        check("stream_end_addr", mem_addr, 12);
        check("stream_end_cnt", word_cnt, 12);

        // Backpressure: three stalled cycles, then no-gap handoff
        sa8 = 8'h10; start = 1'b1; tick(); start = 1'b0;
        set_add(); mem_ready = 1'b0; in_valid = 1'b1;
        tick();
        check("bp_first_we", mem_we, 1);
        cls = 3'd7; rd = 5'd3; imm = 20'h12345;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_in_ready%0d", k), in_ready, 0);
            tick();
            check($sformatf("bp_we%0d", k), mem_we, 1);
            check($sformatf("bp_addr%0d", k), mem_addr, 8'h10);
            check($sformatf("bp_wdata%0d", k), mem_wdata, 32'h003100B3);
        end
        mem_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_next_we", mem_we, 1);
        check("bp_next_addr", mem_addr, 8'h11);
        check("bp_next_wdata", mem_wdata, 32'h123451B7);
        in_valid = 1'b0;
        tick();
        check("bp_done_we", mem_we, 0);
        check("bp_done_cnt", word_cnt, 2);

        // Small instance: start at 2, two writes fill it, third bundle refused
        sa2 = 2'd2; start = 1'b1; tick(); start = 1'b0;
        set_add(); in_valid = 1'b1; mem_ready = 1'b1;
        tick();
        check("s_first_addr", s_mem_addr, 2);
        check("s_first_wdata", s_mem_wdata, 32'h003100B3);
        tick();
        check("s_second_addr", s_mem_addr, 3);
        check("s_second_we", s_mem_we, 1);
        #1;
        check("s_third_ready", s_in_ready, 0);
        tick();
        check("s_full", s_full, 1);
        check("s_busy", s_busy, 0);
        check("s_cnt", s_word_cnt, 2);
        check("s_we_after_full", s_mem_we, 0);
        tick();
        check("s_full_ignore_we", s_mem_we, 0);
        check("s_full_ignore_ready", s_in_ready, 0);
        check("s_err_quiet", s_err, 0);
        in_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("s_restart_busy", s_busy, 1);
        check("s_restart_full", s_full, 0);
        check("s_restart_cnt", s_word_cnt, 0);
        check("s_restart_addr", s_mem_addr, 2);

        // Main instance at top address: one write, then FULL with wrap
        sa8 = 8'hFF; start = 1'b1; tick(); start = 1'b0;
        set_add(); in_valid = 1'b1;
        tick();
        check("top_we", mem_we, 1);
        check("top_addr", mem_addr, 8'hFF);
        #1;
        check("top_ready", in_ready, 0);
        tick();
        check("top_full", full, 1);
        check("top_wrap_addr", mem_addr, 0);
        check("top_cnt", word_cnt, 1);
        in_valid = 1'b0;

        // Illegal branch: err pulse only, nothing written
        sa8 = 8'h40; start = 1'b1; tick(); start = 1'b0;
        cls = 3'd4; funct3 = 3'd2; imm = 20'h00004; in_valid = 1'b1;
        tick();
        check("ill_err", err, 1);
        check("ill_we", mem_we, 0);
        check("ill_addr", mem_addr, 8'h40);
        in_valid = 1'b0;
        tick();
        check("ill_err_pulse", err, 0);
        check("ill_cnt", word_cnt, 0);

        // start while a write is stalled
        sa8 = 8'h20; start = 1'b1; tick(); start = 1'b0;
        set_add(); in_valid = 1'b1; mem_ready = 1'b0;
        tick();
        check("ps_pending_we", mem_we, 1);
        sa8 = 8'h33; start = 1'b1;
        #1;
        check("ps_start_ready", in_ready, 0);
        tick(); start = 1'b0;
        check("ps_we", mem_we, 0);
        check("ps_addr", mem_addr, 8'h33);
        check("ps_cnt", word_cnt, 0);
        check("ps_busy", busy, 1);

        // Reset mid-stream
        mem_ready = 1'b1;
        tick();
        check("mr_we", mem_we, 1);
        rst = 1'b1;
        tick();
        check("mr_rst_we", mem_we, 0);
        check("mr_rst_addr", mem_addr, 0);
        check("mr_rst_wdata", mem_wdata, 0);
        check("mr_rst_busy", busy, 0);
        check("mr_rst_cnt", word_cnt, 0);
        check("mr_rst_ready", in_ready, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("mr_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
